mem_burst_sequencer: RTL and testbench

Downstream stage of the CPU memory bus: consumes the burst-tagged external memory request stream (`mem_req_*` / `mem_resp_*`) and sequences it onto a single-beat, in-order backing-memory command port (`dram_*`). Read bursts are expanded into consecutive word commands, and the returned data is buffered in a credit-controlled response FIFO. Writes pass through as single-beat commands. The block never drops or reorders data.

---
 rtl/mem_burst_sequencer.sv | 136 +++++++++++++
 tb/tb_mem_burst_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_sequencer.sv
// Burst sequencer between the CPU memory request stream and a single-beat, in-order DRAM port.
// Read bursts expand into word commands; returned data lands in a credit-protected response FIFO.
module mem_burst_sequencer #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int RESP_DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mem_req_valid,
   output logic                    mem_req_ready,
   input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
   input  logic                    mem_req_we,
   input  logic [DATA_WIDTH-1:0]   mem_req_wdata,
   input  logic [DATA_WIDTH/8-1:0] mem_req_be,
   input  logic [2:0]              mem_req_burst_len,
   output logic                    mem_resp_valid,
   input  logic                    mem_resp_ready,
   output logic [DATA_WIDTH-1:0]   mem_resp_rdata,
   output logic                    dram_cmd_valid,
   input  logic                    dram_cmd_ready,
   output logic [ADDR_WIDTH-1:0]   dram_cmd_addr,
   output logic                    dram_cmd_we,
   output logic [DATA_WIDTH-1:0]   dram_cmd_wdata,
   output logic [DATA_WIDTH/8-1:0] dram_cmd_be,
   input  logic                    dram_rd_valid,
   input  logic [DATA_WIDTH-1:0]   dram_rd_data,
   output logic                    busy
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int CNT_W = $clog2(RESP_DEPTH + 1);
   localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(BE_W);

   typedef enum logic [1:0] {IDLE, RD_ISSUE, WR_ISSUE} state_t;

   state_t                  state_q;
   logic                    reqReady_q;
   logic [ADDR_WIDTH-1:0]   curAddr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [BE_W-1:0]         be_q;
   logic [3:0]              beatsLeft_q;
   logic [CNT_W-1:0]        outstanding_q, outstanding_d;
   logic [CNT_W-1:0]        fifoCount_q, fifoCount_d;
   logic [PTR_W-1:0]        wrPtr_q, rdPtr_q;
   logic [DATA_WIDTH-1:0]   fifoMem_q [RESP_DEPTH];

   logic reqFire, cmdFire, credit, issue, push, pop;

   // Credit counts both in-flight reads and buffered beats, so every issued read has a FIFO slot.
   assign credit  = ({1'b0, outstanding_q} + {1'b0, fifoCount_q}) < (CNT_W+1)'(RESP_DEPTH);
   assign reqFire = mem_req_valid && reqReady_q;
   assign cmdFire = dram_cmd_valid && dram_cmd_ready;
   assign issue   = cmdFire && (state_q == RD_ISSUE);
   assign push    = dram_rd_valid && (outstanding_q != '0);
   assign pop     = (fifoCount_q != '0) && mem_resp_ready;

   assign mem_req_ready  = reqReady_q;
   assign dram_cmd_valid = (state_q == WR_ISSUE) || ((state_q == RD_ISSUE) && credit);
   assign dram_cmd_addr  = curAddr_q;
   assign dram_cmd_we    = (state_q == WR_ISSUE);
   assign dram_cmd_wdata = wdata_q;
   assign dram_cmd_be    = (state_q == RD_ISSUE) ? {BE_W{1'b1}} : be_q;
   assign mem_resp_valid = (fifoCount_q != '0);
   assign mem_resp_rdata = (fifoCount_q != '0) ? fifoMem_q[rdPtr_q] : '0;
   assign busy           = (state_q != IDLE) || (outstanding_q != '0) || (fifoCount_q != '0);

   // Request FSM: accepts one request in IDLE, then issues its beats without waiting for data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         reqReady_q  <= 1'b0;
         curAddr_q   <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         beatsLeft_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               reqReady_q <= 1'b1;
               if (reqFire) begin
                  curAddr_q   <= mem_req_addr;
                  wdata_q     <= mem_req_wdata;
                  be_q        <= mem_req_be;
                  beatsLeft_q <= {1'b0, mem_req_burst_len} + 4'd1;
                  reqReady_q  <= 1'b0;
                  state_q     <= mem_req_we ? WR_ISSUE : RD_ISSUE;
               end
            end
            RD_ISSUE: begin
               if (cmdFire) begin
                  curAddr_q   <= curAddr_q + STRIDE;
                  beatsLeft_q <= beatsLeft_q - 4'd1;
                  if (beatsLeft_q == 4'd1) begin
                     state_q    <= IDLE;
                     reqReady_q <= 1'b1;
                  end
               end
            end
            WR_ISSUE: begin
               if (cmdFire) begin
                  state_q    <= IDLE;
                  reqReady_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(push);
      fifoCount_d   = fifoCount_q + CNT_W'(push) - CNT_W'(pop);
   end

   // Returns arriving with nothing outstanding are leftovers from before a reset and are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding_q <= '0;
         fifoCount_q   <= '0;
         wrPtr_q       <= '0;
         rdPtr_q       <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         fifoCount_q   <= fifoCount_d;
         if (push) wrPtr_q <= (wrPtr_q == PTR_W'(RESP_DEPTH-1)) ? '0 : wrPtr_q + 1'b1;
         if (pop)  rdPtr_q <= (rdPtr_q == PTR_W'(RESP_DEPTH-1)) ? '0 : rdPtr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifoMem_q[wrPtr_q] <= dram_rd_data;
   end

endmodule

// File: tb/tb_mem_burst_sequencer.sv
// Self-checking bench for mem_burst_sequencer: a transaction-level model predicts every command,
// response and status output; a DRAM responder with variable latency answers the DUT's reads.
module tb_mem_burst_sequencer;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req_valid, mem_req_ready, mem_req_we;
   logic [63:0] mem_req_addr, mem_req_wdata;
   logic [7:0]  mem_req_be;
   logic [2:0]  mem_req_burst_len;
   logic        mem_resp_valid, mem_resp_ready;
   logic [63:0] mem_resp_rdata;
   logic        dram_cmd_valid, dram_cmd_ready, dram_cmd_we;
   logic [63:0] dram_cmd_addr, dram_cmd_wdata;
   logic [7:0]  dram_cmd_be;
   logic        dram_rd_valid = 1'b0;
   logic [63:0] dram_rd_data = '0;
   logic        busy;

   typedef struct {
      logic [63:0] addr;
      logic        we;
      logic [63:0] wdata;
      logic [7:0]  be;
      int          elig;
   } cmd_t;

   cmd_t        expCmdQ[$];
   logic [63:0] expRespQ[$];
   int          dramDue[$];
   logic [63:0] dramDat[$];
   int          modelOut = 0, modelOcc = 0, cyc = 0, cmdCount = 0, dramLat = 3, lastDue = 0;
   int          checks = 0, failures = 0;

   mem_burst_sequencer #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .RESP_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
      .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
      .mem_req_burst_len(mem_req_burst_len),
      .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
      .mem_resp_rdata(mem_resp_rdata),
      .dram_cmd_valid(dram_cmd_valid), .dram_cmd_ready(dram_cmd_ready),
      .dram_cmd_addr(dram_cmd_addr), .dram_cmd_we(dram_cmd_we),
      .dram_cmd_wdata(dram_cmd_wdata), .dram_cmd_be(dram_cmd_be),
      .dram_rd_valid(dram_rd_valid), .dram_rd_data(dram_rd_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Memory contents as a pure function of address; 0x8000_0000 onward reads back 0xA0, 0xA1, ...
   function automatic logic [63:0] memData(input logic [63:0] a);
      return (a >> 3) - 64'h1000_0000 + 64'hA0;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference model and DRAM responder, evaluated once per cycle on the falling edge.
   initial begin
      cmd_t        hd;
      logic        prevRst, prevStall, expValid, readyExp, issue, retPush, popNow;
      prevRst   = 1'b1;
      prevStall = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         readyExp = !prevRst && (expCmdQ.size() == 0);
         expValid = !prevRst && (expCmdQ.size() != 0) && (expCmdQ[0].elig <= cyc) &&
                    (expCmdQ[0].we || (modelOut + modelOcc < DEPTH));
         if (prevRst) begin
            checkOutput("rstReqReady", mem_req_ready, 0);
            checkOutput("rstCmdValid", dram_cmd_valid, 0);
            checkOutput("rstRespValid", mem_resp_valid, 0);
            checkOutput("rstBusy", busy, 0);
            checkOutput("rstCmdAddr", dram_cmd_addr, 0);
            checkOutput("rstCmdWe", dram_cmd_we, 0);
            checkOutput("rstCmdWdata", dram_cmd_wdata, 0);
            checkOutput("rstCmdBe", dram_cmd_be, 0);
            checkOutput("rstRdata", mem_resp_rdata, 0);
         end else begin
            checkOutput("reqReady", mem_req_ready, readyExp);
            checkOutput("cmdValid", dram_cmd_valid, expValid);
            if (prevStall) checkOutput("cmdHold", dram_cmd_valid, 1);
            if (dram_cmd_valid && expCmdQ.size() != 0) begin
               checkOutput("cmdAddr", dram_cmd_addr, expCmdQ[0].addr);
               checkOutput("cmdWe", dram_cmd_we, expCmdQ[0].we);
               checkOutput("cmdBe", dram_cmd_be, expCmdQ[0].be);
               if (expCmdQ[0].we) checkOutput("cmdWdata", dram_cmd_wdata, expCmdQ[0].wdata);
            end
            checkOutput("respValid", mem_resp_valid, modelOcc != 0);
            if (mem_resp_valid && modelOcc != 0) checkOutput("respData", mem_resp_rdata, expRespQ[0]);
            checkOutput("busy", busy, (expCmdQ.size() != 0) || (modelOut != 0) || (modelOcc != 0));
         end

         if (dramDue.size() != 0 && dramDue[0] == cyc) begin
            dram_rd_valid = 1'b1;
            dram_rd_data  = dramDat.pop_front();
            void'(dramDue.pop_front());
         end else begin
            dram_rd_valid = 1'b0;
            dram_rd_data  = '0;
         end

         prevStall = 1'b0;
         if (rst) begin
            expCmdQ.delete();
            expRespQ.delete();
            modelOut = 0;
            modelOcc = 0;
         end else begin
            issue = 0; retPush = 0; popNow = 0;
            if (dram_cmd_valid && dram_cmd_ready && !dram_cmd_we) begin
               lastDue = (cyc + dramLat > lastDue + 1) ? cyc + dramLat : lastDue + 1;
               dramDue.push_back(lastDue);
               dramDat.push_back(memData(dram_cmd_addr));
            end
            if (dram_cmd_valid && !dram_cmd_ready) prevStall = 1'b1;
            if (expValid && dram_cmd_ready) begin
               hd = expCmdQ.pop_front();
               cmdCount++;
               if (!hd.we) issue = 1;
            end
            if (dram_rd_valid && modelOut > 0) begin
               expRespQ.push_back(dram_rd_data);
               retPush = 1;
            end
            if (modelOcc > 0 && mem_resp_ready) begin
               void'(expRespQ.pop_front());
               popNow = 1;
            end
            modelOut = modelOut + int'(issue) - int'(retPush);
            modelOcc = modelOcc + int'(retPush) - int'(popNow);
            if (mem_req_valid && readyExp) begin
               if (mem_req_we) begin
                  expCmdQ.push_back('{mem_req_addr, 1'b1, mem_req_wdata, mem_req_be, cyc + 1});
               end else begin
                  for (int i = 0; i <= int'(mem_req_burst_len); i++)
                     expCmdQ.push_back('{mem_req_addr + 64'(8 * i), 1'b0, 64'h0, 8'hFF, cyc + 1});
               end
            end
         end
         prevRst = rst;
      end
   end

   task automatic applyStimulus(input logic [63:0] addr, input logic we, input logic [63:0] wdata,
                                input logic [7:0] be, input logic [2:0] len, output int acceptCyc);
      @(posedge clk); #1;
      mem_req_addr = addr; mem_req_we = we; mem_req_wdata = wdata;
      mem_req_be = be; mem_req_burst_len = len; mem_req_valid = 1'b1;
      acceptCyc = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); #1;
         if (mem_req_ready) begin
            acceptCyc = cyc;
            break;
         end
      end
      @(posedge clk); #1;
      mem_req_valid = 1'b0;
      if (acceptCyc < 0) checkOutput("reqTimeout", 0, 1);
   endtask

   task automatic waitIdle(input int maxCycles);
      bit done = 0;
      for (int i = 0; i < maxCycles; i++) begin
         @(negedge clk); #1;
         if (expCmdQ.size() == 0 && modelOut == 0 && modelOcc == 0 && dramDue.size() == 0) begin
            done = 1;
            break;
         end
      end
      if (!done) checkOutput("idleTimeout", 0, 1);
   endtask

   initial begin
      int acc, lat, base;
      bit hs;
      mem_req_valid = 0; mem_req_we = 0; mem_req_addr = '0; mem_req_wdata = '0;
      mem_req_be = '0; mem_req_burst_len = '0; dram_cmd_ready = 1; mem_resp_ready = 1;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); @(negedge clk); #1;
      checkOutput("postRstReady", mem_req_ready, 1);
      checkOutput("postRstBusy", busy, 0);

      dramLat = 3;
      applyStimulus(64'h8000_0000, 1'b0, 64'h0, 8'h00, 3'd7, acc);
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (mem_resp_valid) begin
            lat = cyc - acc;
            break;
         end
      end
      checkOutput("firstRespLat", 64'(lat), 5);
      checkOutput("firstRespData", mem_resp_rdata, 64'hA0);
      waitIdle(100);

      @(posedge clk); #1;
      mem_resp_ready = 0;
      dramLat = 2;
      base = cmdCount;
      applyStimulus(64'h0000_1000, 1'b0, 64'h0, 8'h00, 3'd7, acc);
      applyStimulus(64'h0000_2000, 1'b0, 64'h0, 8'h00, 3'd7, acc);
      repeat (20) @(posedge clk);
      #1;
      checkOutput("creditStall", 64'(cmdCount - base), 8);
      mem_resp_ready = 1;
      repeat (3) @(posedge clk);
      #1 mem_resp_ready = 0;
      repeat (15) @(posedge clk);
      #1;
      checkOutput("creditRelease", 64'(cmdCount - base), 11);
      mem_resp_ready = 1;
      waitIdle(200);

      @(posedge clk); #1;
      dram_cmd_ready = 0;
      base = cmdCount;
      applyStimulus(64'h8000_0100, 1'b1, 64'hDEAD_BEEF, 8'h0F, 3'd0, acc);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("wrHeld", 64'(cmdCount - base), 0);
      dram_cmd_ready = 1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("wrAcceptedOnce", 64'(cmdCount - base), 1);
      waitIdle(50);

      applyStimulus(64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 64'h0, 8'h00, 3'd1, acc);
      waitIdle(100);

      dramLat = 3;
      base = cmdCount;
      applyStimulus(64'h0000_4000, 1'b0, 64'h0, 8'h00, 3'd3, acc);
      for (int i = 0; i < 50 && cmdCount - base < 2; i++) begin
         @(negedge clk); #1;
      end
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      waitIdle(100);
      checkOutput("staleDiscard", mem_resp_valid, 0);
      checkOutput("afterRstIssued", 64'(cmdCount - base), 2);
      applyStimulus(64'h0000_4000, 1'b0, 64'h0, 8'h00, 3'd0, acc);
      waitIdle(100);

      for (int c = 0; c < 2500; c++) begin
         @(negedge clk); #1;
         hs = mem_req_valid && mem_req_ready;
         @(posedge clk); #1;
         if (hs) mem_req_valid = 0;
         dram_cmd_ready = ($urandom % 4) != 0;
         mem_resp_ready = ($urandom % 3) != 0;
         if ($urandom % 64 == 0) dramLat = $urandom_range(1, 5);
         if (!mem_req_valid && ($urandom % 4) == 0) begin
            mem_req_addr      = {$urandom, $urandom} & ~64'h7;
            mem_req_we        = ($urandom % 3) == 0;
            mem_req_wdata     = {$urandom, $urandom};
            mem_req_be        = 8'($urandom);
            mem_req_burst_len = 3'($urandom);
            mem_req_valid     = 1;
         end
      end
      mem_req_valid  = 0;
      dram_cmd_ready = 1;
      mem_resp_ready = 1;
      waitIdle(500);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
